timer_cmd_tx: RTL and testbench

Command transmitter for the review2015 serial timer. It accepts a 4-bit delay value over a start/ready handshake and serialises it on a 1-bit line. The frame is the start pattern 1101 followed by the delay bits, MSB first. It then waits for the timer's done, answers with a one-cycle ack, and returns to idle. A watchdog aborts the transaction if done never arrives.

---
 rtl/timer_cmd_tx.sv | 109 ++++++++++
 tb/tb_timer_cmd_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_cmd_tx.sv
// Command transmitter for the serial timer: sends PATTERN then the latched
// delay MSB first on a registered line, waits for done (with watchdog), then acks.
module timer_cmd_tx #(
    parameter logic [3:0] PATTERN = 4'b1101,
    parameter int         DELAY_W = 4,
    parameter int         TIMEOUT = 20000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DELAY_W-1:0] delay,
    output logic               ready,
    output logic               data,
    input  logic               done,
    output logic               ack,
    output logic               timeout,
    output logic               busy
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    localparam logic [2:0] PAY_LAST_IDX = 3'(DELAY_W - 1);

    typedef enum logic [2:0] {IDLE, PRE, PAY, WAIT_DONE, ACK} state_t;

    state_t             state;
    logic [2:0]         bit_idx;
    logic [3:0]         pat_shift;
    logic [DELAY_W-1:0] delay_latched;
    logic [WD_W-1:0]    wd_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bit_idx       <= '0;
            pat_shift     <= '0;
            delay_latched <= '0;
            wd_count      <= '0;
            data          <= 1'b0;
            ack           <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            ack     <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    data <= 1'b0;
                    if (start) begin
                        // First pattern bit goes out on the accepting edge itself.
                        state         <= PRE;
                        delay_latched <= delay;
                        data          <= PATTERN[3];
                        pat_shift     <= PATTERN << 1;
                        bit_idx       <= 3'd3;
                    end
                end
                PRE: begin
                    if (bit_idx != 3'd0) begin
                        data      <= pat_shift[3];
                        pat_shift <= pat_shift << 1;
                        bit_idx   <= bit_idx - 3'd1;
                    end else begin
                        state         <= PAY;
                        data          <= delay_latched[DELAY_W-1];
                        delay_latched <= delay_latched << 1;
                        bit_idx       <= PAY_LAST_IDX;
                    end
                end
                PAY: begin
                    if (bit_idx != 3'd0) begin
                        data          <= delay_latched[DELAY_W-1];
                        delay_latched <= delay_latched << 1;
                        bit_idx       <= bit_idx - 3'd1;
                    end else begin
                        state    <= WAIT_DONE;
                        data     <= 1'b0;
                        wd_count <= '0;
                    end
                end
                WAIT_DONE: begin
                    data <= 1'b0;
                    if (wd_count != WD_MAX) begin
                        wd_count <= wd_count + 1'b1;
                    end
                    // done takes priority over a watchdog expiry on the same edge.
                    if (done) begin
                        state <= ACK;
                        ack   <= 1'b1;
                    end else if (wd_count == WD_LAST) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end
                end
                ACK: begin
                    data  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    data  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_timer_cmd_tx.sv
// Directed bench for timer_cmd_tx: table-driven frames plus hand sequences for
// held start, watchdog expiry, async reset mid-frame and done corner cases.
module tb_timer_cmd_tx;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [3:0] delay;
    logic       ready;
    logic       data;
    logic       ack;
    logic       timeout;
    logic       busy;

    int total  = 0;
    int passed = 0;

    timer_cmd_tx #(
        .PATTERN(4'b1101),
        .DELAY_W(4),
        .TIMEOUT(50)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .delay  (delay),
        .ready  (ready),
        .data   (data),
        .done   (done),
        .ack    (ack),
        .timeout(timeout),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [7:0] frame;
        int         wait_cycles;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle right after the accepting edge; leaves us in the last payload cycle.
    task automatic check_frame(input logic [7:0] frame, input string tag);
        for (int i = 0; i < 8; i++) begin
            if (i != 0) tick;
            chk($sformatf("%s data bit%0d", tag, i), {31'd0, data}, {31'd0, frame[7-i]});
            chk($sformatf("%s busy bit%0d", tag, i), {31'd0, busy}, 32'd1);
            chk($sformatf("%s ready bit%0d", tag, i), {31'd0, ready}, 32'd0);
        end
    endtask

    // From the last payload cycle: enter WAIT_DONE, wait, raise done, check ack pulse.
    task automatic finish_with_done(input int wait_cycles, input string tag);
        tick;
        chk({tag, " wait data"}, {31'd0, data}, 32'd0);
        for (int i = 0; i < wait_cycles; i++) begin
            tick;
            chk({tag, " wait ack"}, {31'd0, ack}, 32'd0);
        end
        done = 1'b1;
        tick;
        done = 1'b0;
        chk({tag, " ack"}, {31'd0, ack}, 32'd1);
        chk({tag, " ack timeout"}, {31'd0, timeout}, 32'd0);
        chk({tag, " ack ready"}, {31'd0, ready}, 32'd0);
        tick;
        chk({tag, " post ack"}, {31'd0, ack}, 32'd0);
        chk({tag, " post ready"}, {31'd0, ready}, 32'd1);
        chk({tag, " post data"}, {31'd0, data}, 32'd0);
    endtask

    initial begin
        int  cnt;
        logic ack_seen;

        vecs[0] = '{4'b0101, 8'b1101_0101, 2};
        vecs[1] = '{4'b0000, 8'b1101_0000, 0};
        vecs[2] = '{4'b1111, 8'b1101_1111, 5};
        vecs[3] = '{4'b1001, 8'b1101_1001, 1};

        reset = 1'b1; start = 1'b0; done = 1'b0; delay = 4'd0;
        repeat (2) tick;
        chk("reset ready", {31'd0, ready}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset data", {31'd0, data}, 32'd0);
        chk("reset ack", {31'd0, ack}, 32'd0);
        chk("reset timeout", {31'd0, timeout}, 32'd0);
        reset = 1'b0;
        tick;

        // Table-driven frames with done after a varying wait.
        for (int v = 0; v < 4; v++) begin
            start = 1'b1; delay = vecs[v].d;
            tick;
            start = 1'b0; delay = ~vecs[v].d;
            check_frame(vecs[v].frame, $sformatf("vec%0d", v));
            finish_with_done(vecs[v].wait_cycles, $sformatf("vec%0d", v));
            $display("vec%0d delay=%b frame=%b done", v, vecs[v].d, vecs[v].frame);
        end

        // start held high: second frame only after ack, mid-frame delay change ignored.
        start = 1'b1; delay = 4'b1010;
        tick;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) tick;
            if (i == 4) delay = 4'b0110;
            chk($sformatf("held f1 bit%0d", i), {31'd0, data}, {31'd0, 8'b1101_1010 >> (7 - i)} & 32'd1);
            chk($sformatf("held f1 ready%0d", i), {31'd0, ready}, 32'd0);
        end
        tick;
        chk("held wait ready", {31'd0, ready}, 32'd0);
        done = 1'b1;
        tick;
        done = 1'b0;
        chk("held ack", {31'd0, ack}, 32'd1);
        tick;
        chk("held idle ready", {31'd0, ready}, 32'd1);
        chk("held idle data", {31'd0, data}, 32'd0);
        tick;
        start = 1'b0;
        check_frame(8'b1101_0110, "held f2");
        finish_with_done(0, "held f2");
        $display("held start: two frames 11011010 / 11010110");

        // Watchdog expiry with done held low.
        start = 1'b1; delay = 4'b0011;
        tick;
        start = 1'b0;
        check_frame(8'b1101_0011, "to");
        tick;
        cnt = 0; ack_seen = 1'b0;
        while (!timeout && cnt < 200) begin
            tick;
            cnt++;
            if (ack) ack_seen = 1'b1;
        end
        chk("to cycles", 32'(cnt), 32'd50);
        chk("to no ack", {31'd0, ack_seen}, 32'd0);
        chk("to ready", {31'd0, ready}, 32'd1);
        tick;
        chk("to pulse width", {31'd0, timeout}, 32'd0);
        chk("to ready next", {31'd0, ready}, 32'd1);
        $display("timeout after %0d cycles", cnt);

        // Async reset while sending payload bit 1.
        start = 1'b1; delay = 4'b1111;
        tick;
        start = 1'b0;
        repeat (6) tick;
        chk("rst pre data", {31'd0, data}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst async data", {31'd0, data}, 32'd0);
        chk("rst async ack", {31'd0, ack}, 32'd0);
        chk("rst async ready", {31'd0, ready}, 32'd1);
        tick;
        reset = 1'b0;
        start = 1'b1; delay = 4'b0101;
        tick;
        start = 1'b0;
        check_frame(8'b1101_0101, "rst next");
        finish_with_done(1, "rst next");
        $display("reset mid-PAY then clean frame");

        // done during PRE ignored; done on final watchdog cycle wins.
        start = 1'b1; delay = 4'b1100;
        tick;
        start = 1'b0;
        done = 1'b1;
        tick;
        done = 1'b0;
        chk("pre done data", {31'd0, data}, 32'd1);
        chk("pre done busy", {31'd0, busy}, 32'd1);
        repeat (6) tick;
        chk("pre done last bit", {31'd0, data}, 32'd0);
        tick;
        chk("pre done wait ack", {31'd0, ack}, 32'd0);
        repeat (49) tick;
        chk("final cycle timeout", {31'd0, timeout}, 32'd0);
        done = 1'b1;
        tick;
        done = 1'b0;
        chk("final done ack", {31'd0, ack}, 32'd1);
        chk("final done timeout", {31'd0, timeout}, 32'd0);
        tick;
        chk("final post timeout", {31'd0, timeout}, 32'd0);
        chk("final post ready", {31'd0, ready}, 32'd1);
        $display("done on last watchdog cycle acked");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
